// File: rtl/calculator_pkg.sv
// Shared sizing constants and bank state encoding for the calculator result path.
package calculator_pkg;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 2 * DATA_W;
  localparam int NUM_BANKS     = 2;

  typedef enum logic [1:0] {
    B_EMPTY = 2'd0,
    B_HALF  = 2'd1,
    B_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/result_bank.sv
// One memory-word bank: lower/upper data halves, its fill state and, when the
// RESULT_BUFFER_CARRY_EN macro is defined, one carry bit per half.
module result_bank
  import calculator_pkg::*;
#(
  parameter int DATA_W        = calculator_pkg::DATA_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_lo_i,
  input  logic                     wr_hi_i,
  input  logic                     clear_i,
  input  logic [DATA_W-1:0]        data_i,
`ifdef RESULT_BUFFER_CARRY_EN
  input  logic                     carry_i,
  output logic [1:0]               carries_o,
`endif
  output buf_state_t               state_o,
  output logic [MEM_WORD_SIZE-1:0] word_o
);

  buf_state_t                     state_q, state_d;
  logic [DATA_W-1:0]              lo_q, lo_d;
  logic [MEM_WORD_SIZE-DATA_W-1:0] hi_q, hi_d;

  // Next-state: a pop empties the bank; a lower write (re)starts the word; an upper write completes it.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (clear_i) begin
      state_d = B_EMPTY;
      lo_d    = '0;
      hi_d    = '0;
    end else if (wr_lo_i) begin
      state_d = B_HALF;
      lo_d    = data_i;
    end else if (wr_hi_i) begin
      state_d = B_FULL;
      hi_d    = (MEM_WORD_SIZE-DATA_W)'(data_i);
    end
  end

  // Bank storage, wiped asynchronously so no partial word survives reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= B_EMPTY;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign state_o = state_q;
  assign word_o  = {hi_q, lo_q};

`ifdef RESULT_BUFFER_CARRY_EN
  logic [1:0] carry_q, carry_d;

  // Carry bits follow the same write/clear rules as their data halves.
  always_comb begin
    carry_d = carry_q;
    if (clear_i)      carry_d = 2'b00;
    else if (wr_lo_i) carry_d[0] = carry_i;
    else if (wr_hi_i) carry_d[1] = carry_i;
  end

  // Carry storage, cleared with the data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) carry_q <= 2'b00;
    else       carry_q <= carry_d;
  end

  assign carries_o = carry_q;
`endif

endmodule

// File: rtl/result_buffer.sv
// Two-bank buffer that pairs adder results into memory words {upper, lower}.
// Optional feature macro: RESULT_BUFFER_CARRY_EN (per-half carry and sticky overflow).
module result_buffer
  import calculator_pkg::*;
#(
  parameter int DATA_W        = calculator_pkg::DATA_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic                     buffer_control,
  input  logic [DATA_W-1:0]        result_i,
  input  logic                     carry_i,
  output logic                     ready_o,
  input  logic                     write,
  output logic [MEM_WORD_SIZE-1:0] buff_result,
  output logic                     buff_valid_o,
  output logic [1:0]               carry_o,
  output logic                     overflow_o,
  output logic                     err_o
);

  logic       wb_q, wb_d;
  logic       rb_q, rb_d;
  logic [1:0] count_q, count_d;
  logic       err_q, err_d;

  logic [NUM_BANKS-1:0]     bank_wr_lo, bank_wr_hi, bank_clear;
  buf_state_t               bank_state [NUM_BANKS];
  logic [MEM_WORD_SIZE-1:0] bank_word  [NUM_BANKS];

  logic       accept, pop, lo_req, hi_req, complete, head_full;
  buf_state_t fill_state;

  assign ready_o    = (count_q < 2'd2);
  assign accept     = valid_i && ready_o;
  assign lo_req     = accept && !buffer_control;
  assign hi_req     = accept && buffer_control;
  assign fill_state = bank_state[wb_q];
  assign head_full  = (bank_state[rb_q] == B_FULL);
  assign pop        = write && head_full;
  assign complete   = hi_req && (fill_state == B_HALF);

  // Route write/clear commands to the fill bank and head bank; an upper half to an empty bank is dropped.
  always_comb begin
    bank_wr_lo = '0;
    bank_wr_hi = '0;
    bank_clear = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (int'(wb_q) == i) begin
        bank_wr_lo[i] = lo_req;
        bank_wr_hi[i] = complete;
      end
      if (int'(rb_q) == i) bank_clear[i] = pop;
    end
  end

  // Pointer, occupancy and sticky protocol-error bookkeeping.
  always_comb begin
    wb_d    = complete ? ~wb_q : wb_q;
    rb_d    = pop ? ~rb_q : rb_q;
    count_d = count_q + {1'b0, complete} - {1'b0, pop};
    err_d   = err_q
            | (valid_i && !ready_o)
            | (lo_req && (fill_state == B_HALF))
            | (hi_req && (fill_state == B_EMPTY))
            | (write && !head_full);
  end

  // Control registers, all cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      count_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign err_o        = err_q;
  assign buff_valid_o = head_full;
  assign buff_result  = head_full ? bank_word[rb_q] : '0;

`ifdef RESULT_BUFFER_CARRY_EN
  logic [1:0] bank_carry [NUM_BANKS];
  logic       overflow_q, overflow_d;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    result_bank #(.DATA_W(DATA_W), .MEM_WORD_SIZE(MEM_WORD_SIZE)) u_bank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_lo_i   (bank_wr_lo[g]),
      .wr_hi_i   (bank_wr_hi[g]),
      .clear_i   (bank_clear[g]),
      .data_i    (result_i),
      .carry_i   (carry_i),
      .carries_o (bank_carry[g]),
      .state_o   (bank_state[g]),
      .word_o    (bank_word[g])
    );
  end

  // Sticky overflow over every accepted result, including ones later dropped as misordered.
  always_comb begin
    overflow_d = overflow_q | (accept && carry_i);
  end

  // Overflow register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;
  assign carry_o    = head_full ? bank_carry[rb_q] : 2'b00;
`else
  logic unused_carry;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    result_bank #(.DATA_W(DATA_W), .MEM_WORD_SIZE(MEM_WORD_SIZE)) u_bank (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr_lo_i (bank_wr_lo[g]),
      .wr_hi_i (bank_wr_hi[g]),
      .clear_i (bank_clear[g]),
      .data_i  (result_i),
      .state_o (bank_state[g]),
      .word_o  (bank_word[g])
    );
  end

  assign unused_carry = carry_i;
  assign overflow_o   = 1'b0;
  assign carry_o      = 2'b00;
`endif

endmodule

// File: tb/tb_result_buffer.sv
// Directed self-checking bench for result_buffer.
module tb_result_buffer;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     valid_i = 1'b0;
  logic                     buffer_control = 1'b0;
  logic [DATA_W-1:0]        result_i = '0;
  logic                     carry_i = 1'b0;
  logic                     ready_o;
  logic                     write = 1'b0;
  logic [MEM_WORD_SIZE-1:0] buff_result;
  logic                     buff_valid_o;
  logic [1:0]               carry_o;
  logic                     overflow_o;
  logic                     err_o;

  int checks = 0;
  int errors = 0;

`ifdef RESULT_BUFFER_CARRY_EN
  localparam logic [1:0] EXP_CARRY    = 2'b10;
  localparam logic       EXP_OVERFLOW = 1'b1;
`else
  localparam logic [1:0] EXP_CARRY    = 2'b00;
  localparam logic       EXP_OVERFLOW = 1'b0;
`endif

  result_buffer #(.DATA_W(DATA_W), .MEM_WORD_SIZE(MEM_WORD_SIZE)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .buffer_control (buffer_control),
    .result_i       (result_i),
    .carry_i        (carry_i),
    .ready_o        (ready_o),
    .write          (write),
    .buff_result    (buff_result),
    .buff_valid_o   (buff_valid_o),
    .carry_o        (carry_o),
    .overflow_o     (overflow_o),
    .err_o          (err_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs, let the rising edge take them, then return to idle 1ns later.
  task automatic applyStimulus(input logic v, input logic bc, input logic [DATA_W-1:0] r,
                               input logic c, input logic w);
    valid_i        = v;
    buffer_control = bc;
    result_i       = r;
    carry_i        = c;
    write          = w;
    @(posedge clk_i);
    #1;
    valid_i        = 1'b0;
    buffer_control = 1'b0;
    result_i       = '0;
    carry_i        = 1'b0;
    write          = 1'b0;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse reset between clock edges so the clear is seen without any clock.
  task automatic pulseReset();
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
  endtask

  initial begin
    // Reset state.
    #2;
    checkOutput("rst_ready",    64'(ready_o),      64'd1);
    checkOutput("rst_valid",    64'(buff_valid_o), 64'd0);
    checkOutput("rst_result",   buff_result,       64'd0);
    checkOutput("rst_carry",    64'(carry_o),      64'd0);
    checkOutput("rst_err",      64'(err_o),        64'd0);
    checkOutput("rst_overflow", 64'(overflow_o),   64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Basic pairing with one-cycle latency.
    applyStimulus(1'b1, 1'b0, 32'h0000_0005, 1'b0, 1'b0);
    checkOutput("half_valid", 64'(buff_valid_o), 64'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0007, 1'b0, 1'b0);
    checkOutput("pair_valid",  64'(buff_valid_o), 64'd1);
    checkOutput("pair_result", buff_result,       64'h0000_0007_0000_0005);
    checkOutput("pair_ready",  64'(ready_o),      64'd1);
    checkOutput("pair_err",    64'(err_o),        64'd0);

    // Both banks full, then an extra result is dropped.
    applyStimulus(1'b1, 1'b0, 32'h0000_000A, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_000B, 1'b0, 1'b0);
    checkOutput("full_ready",  64'(ready_o), 64'd0);
    checkOutput("full_err",    64'(err_o),   64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_000C, 1'b0, 1'b0);
    checkOutput("drop_err",    64'(err_o),   64'd1);
    checkOutput("drop_ready",  64'(ready_o), 64'd0);
    checkOutput("drop_head",   buff_result,  64'h0000_0007_0000_0005);

    // Asynchronous reset clears everything without a clock edge.
    rst_i = 1'b1;
    #1;
    checkOutput("async_err",   64'(err_o),        64'd0);
    checkOutput("async_ready", 64'(ready_o),      64'd1);
    checkOutput("async_valid", 64'(buff_valid_o), 64'd0);
    rst_i = 1'b0;

    // Bank B1 completes in the same cycle that B0 is popped.
    applyStimulus(1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
    checkOutput("pre_pop_head", buff_result, 64'h0000_0002_0000_0001);
    applyStimulus(1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b1);
    checkOutput("swap_valid",  64'(buff_valid_o), 64'd1);
    checkOutput("swap_result", buff_result,       64'h0000_0004_0000_0003);
    checkOutput("swap_ready",  64'(ready_o),      64'd1);
    checkOutput("swap_err",    64'(err_o),        64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
    checkOutput("swap_cnt_full", 64'(ready_o), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("pop_b1_head", buff_result,  64'h0000_0011_0000_0010);
    checkOutput("pop_b1_ready", 64'(ready_o), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("drained_valid",  64'(buff_valid_o), 64'd0);
    checkOutput("drained_result", buff_result,       64'd0);
    checkOutput("drained_err",    64'(err_o),        64'd0);

    // Carry capture and sticky overflow.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    checkOutput("carry_result",   buff_result,       64'hFFFF_FFFF_0000_0000);
    checkOutput("carry_o",        64'(carry_o),      64'(EXP_CARRY));
    checkOutput("carry_overflow", 64'(overflow_o),   64'(EXP_OVERFLOW));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("carry_popped",   64'(carry_o),      64'd0);
    checkOutput("overflow_stick", 64'(overflow_o),   64'(EXP_OVERFLOW));

    // Reset mid-fill discards the partial word.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 32'h0000_0099, 1'b0, 1'b0);
    pulseReset();
    checkOutput("midfill_overflow", 64'(overflow_o), 64'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0055, 1'b0, 1'b0);
    checkOutput("stale_hi_dropped", 64'(buff_valid_o), 64'd0);
    pulseReset();
    applyStimulus(1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
    checkOutput("fresh_result", buff_result, 64'h0000_0002_0000_0001);
    checkOutput("fresh_err",    64'(err_o),  64'd0);

    // Pop with nothing full only flags an error.
    pulseReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("empty_pop_err",   64'(err_o),        64'd1);
    checkOutput("empty_pop_valid", 64'(buff_valid_o), 64'd0);
    checkOutput("empty_pop_ready", 64'(ready_o),      64'd1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0021, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0022, 1'b0, 1'b0);
    checkOutput("after_bad_pop", buff_result, 64'h0000_0022_0000_0021);

    // Upper half into an empty bank is dropped with no state change.
    pulseReset();
    applyStimulus(1'b1, 1'b1, 32'h0000_0077, 1'b0, 1'b0);
    checkOutput("hi_empty_err",   64'(err_o),        64'd1);
    checkOutput("hi_empty_valid", 64'(buff_valid_o), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0009, 1'b0, 1'b0);
    checkOutput("hi_empty_after", buff_result, 64'h0000_0009_0000_0008);
    checkOutput("hi_empty_ready", 64'(ready_o), 64'd1);

    // Second lower half overwrites the first.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0005, 1'b0, 1'b0);
    checkOutput("lo_twice_err",   64'(err_o),        64'd1);
    checkOutput("lo_twice_valid", 64'(buff_valid_o), 64'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0006, 1'b0, 1'b0);
    checkOutput("lo_twice_result", buff_result, 64'h0000_0006_0000_0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_buffer.md
RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one adder result (half word).
REQ-002 SHALL have parameter MEM_WORD_SIZE, default 64 (= 2*DATA_W), width of one memory word.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  result_i valid this cycle.
REQ-006 SHALL have port buffer_control  input  1  target half (1 = upper, 0 = lower).
REQ-007 SHALL have port result_i  input  DATA_W  adder sum.
REQ-008 SHALL have port carry_i  input  1  adder carry-out for result_i.
REQ-009 SHALL have port ready_o  output  1  a bank is free to accept results.
REQ-010 SHALL have port write  input  1  consumer commits head word to memory this cycle (pop).
REQ-011 SHALL have port buff_result  output  MEM_WORD_SIZE  head bank word {upper, lower}.
REQ-012 SHALL have port buff_valid_o  output  1  head bank FULL.
REQ-013 SHALL have port carry_o  output  2  head bank carries {upper, lower}.
REQ-014 SHALL have port overflow_o  output  1  sticky: any accepted carry_i = 1.
REQ-015 SHALL have port err_o  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL hold two banks B0/B1, each with state EMPTY -> HALF -> FULL, a fill pointer wb, a head pointer rb, and count 0..2 of FULL banks.
REQ-017 SHALL assert ready_o iff count < 2; accept = valid_i && ready_o.
REQ-018 SHALL, on accepted lower (buffer_control=0) to EMPTY bank wb, store result_i in bits [DATA_W-1:0] and go HALF.
REQ-019 SHALL, on accepted upper to HALF bank wb, store result_i in bits [MEM_WORD_SIZE-1:DATA_W], go FULL, toggle wb, increment count.
REQ-020 SHALL, on lower to HALF bank, overwrite lower half, stay HALF, set err_o.
REQ-021 SHALL, on upper to EMPTY bank, drop the data, leave state unchanged, set err_o.
REQ-022 SHALL, on valid_i while ready_o=0, drop the data and set err_o.
REQ-023 SHALL, on write && buff_valid_o, set bank rb EMPTY, toggle rb, decrement count; write with buff_valid_o=0 SHALL change nothing except set err_o.
REQ-024 SHALL, on same-cycle bank completion and pop, perform both, count unchanged.
REQ-025 SHALL present bank rb on buff_result/carry_o when FULL, all-zero otherwise; buff_valid_o rises the cycle after the completing upper accept (1-cycle latency).
REQ-026 SHALL not pipeline arithmetic; result_i stored unmodified.

Reset
REQ-027 SHALL, on rst_i (any time, including mid-fill), asynchronously clear banks to zero, states EMPTY, wb=rb=0, count=0, err_o=overflow_o=0; ready_o=1, buff_valid_o=0, buff_result=0, carry_o=0.
REQ-028 SHALL discard partial and full words on reset; no pop is generated.

Configuration
REQ-029 SHALL, with RESULT_BUFFER_CARRY_EN defined, store per-half carry bits and drive carry_o and overflow_o per REQ-013/014.
REQ-030 SHALL, without RESULT_BUFFER_CARRY_EN, ignore carry_i, tie carry_o=0 and overflow_o=0, and instantiate no carry storage.

Structure
REQ-031 SHALL take DATA_W, MEM_WORD_SIZE, NUM_BANKS=2 and enum buf_state_t {B_EMPTY, B_HALF, B_FULL} from calculator_pkg.
REQ-032 SHALL implement each bank as sub-module result_bank (data halves, carries, state), instantiated twice.

Verification
REQ-033 Reset, lower 0x0000_0005 then upper 0x0000_0007 -> next cycle buff_valid_o=1, buff_result=0x0000_0007_0000_0005, ready_o=1.
REQ-034 Fill two words without write, then valid_i -> ready_o=0, data dropped, err_o=1, head word unchanged.
REQ-035 Bank B1 upper completes same cycle as write pops B0 -> count stays 1, next buff_result = B1 word.
REQ-036 Upper 0xFFFF_FFFF with carry_i=1 -> carry_o=2'b10 and overflow_o=1 with macro; both 0 without.
REQ-037 Assert rst_i after lower-only accept, then lower 0x1, upper 0x2 -> buff_result=0x0000_0002_0000_0001, no stale data.
REQ-038 write with buff_valid_o=0, and upper to EMPTY bank -> err_o=1, pointers and states unchanged.
